lnzd_scanner: RTL and testbench
===============================

// Module: lnzd_scanner
// PURPOSE
//  Sequential successor to the combinational LNZD detector. Accepts one DATA_WIDTH-bit
//  sparse vector per handshake and emits the positions of all its nonzero bits, one
//  position per output beat, in LSB-first or MSB-first order.
//  Sits between the activation/hash-bucket producer and the sparse MAC/index stage,
//  turning a bitmap into a stream of nonzero indices tagged with the vector's id.
// PARAMETERS
//  DATA_WIDTH  16  vector width; power of 2, >= 2
//  TAG_WIDTH   8   width of the sideband tag carried with each vector (e.g. row id)
//  MSB_FIRST   0   0: emit ascending positions; 1: emit descending positions
// PORTS
//  clk        in   1                  clock
//  rst_n      in   1                  reset; synchronous, active-low
//  in_data    in   DATA_WIDTH         vector to scan
//  in_tag     in   TAG_WIDTH          sideband tag; copied to every output beat of the vector
//  in_valid   in   1                  input handshake valid
//  in_ready   out  1                  input handshake ready
//  out_pos    out  clog2(DATA_WIDTH)  position of the current nonzero bit
//  out_cnt    out  clog2(DATA_WIDTH)+1  ordinal of this beat within the vector (0-based)
//  out_tag    out  TAG_WIDTH          tag of the vector being scanned
//  out_last   out  1                  final beat of the vector
//  out_empty  out  1                  vector was all-zero; out_pos/out_cnt are 0
//  out_valid  out  1                  output handshake valid
//  out_ready  in   1                  output handshake ready
//  busy       out  1                  a vector is held (state == SCAN)
// BEHAVIOUR
//  - Two states: IDLE, SCAN. Reset (rst_n low at a clk edge) forces IDLE.
//    Reset clears the residual register, tag, and beat counter.
//    After reset: out_valid=0, in_ready=1, busy=0; out_pos, out_cnt, out_tag, out_last,
//    and out_empty are all 0.
//  - Reset during SCAN discards the held vector; no further beats are emitted for it.
//  - Accept: in_valid & in_ready at edge N loads residual<=in_data, tag<=in_tag, cnt<=0,
//    state<=SCAN. The first beat is valid in cycle N+1 (one-cycle latency).
//  - SCAN: out_valid=1. out_pos = leading-nonzero position of residual, counted from bit 0
//    (MSB_FIRST=0) or from bit DATA_WIDTH-1 (MSB_FIRST=1). For MSB_FIRST=1, bit-reverse the
//    residual into the detector and report DATA_WIDTH-1-pos.
//  - out_last=1 when residual has exactly one set bit, or when the vector is empty.
//  - Beat transfer (out_valid & out_ready): clear the reported bit in residual (one-hot
//    decode of out_pos) and increment cnt.
//    On a last beat: return to IDLE, or reload directly if a new vector is accepted in the
//    same cycle.
//  - Stall (out_ready=0): all out_* held stable; residual unchanged.
//  - Empty vector (in_data==0): exactly one beat with out_empty=1, out_last=1, out_pos=0,
//    out_cnt=0.
//  - in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is a combinational
//    path from out_ready; it gives back-to-back vectors with no bubble.
//  - A full vector (all ones) yields DATA_WIDTH beats; out_cnt reaches DATA_WIDTH-1.
//    The out_cnt width holds DATA_WIDTH without wrap.
//  - Throughput: max(1, popcount) cycles per vector when out_ready is held high.
// STRUCTURE
//  - Instantiate the existing radix-2 LNZD module (BIT_WIDTH=DATA_WIDTH) on the optionally
//    bit-reversed residual. Its valid output == "residual nonzero".
//  - Last detection: (residual & (residual-1)) == 0.
//  - clog2 function and state encodings go in the shared LRAHash defines include;
//    no other sub-modules.
// TESTING (DATA_WIDTH=8 unless stated)
//  1. in_data=8'b1001_0100, in_tag=5, out_ready=1.
//     -> out_pos 2,4,7 in cycles N+1..N+3; out_cnt 0,1,2; out_tag=5; out_last only on pos 7;
//     in_ready=1 in that cycle.
//  2. in_data=8'h00, in_tag=9.
//     -> single beat: out_empty=1, out_last=1, out_pos=0, out_cnt=0, out_tag=9; then IDLE.
//  3. in_data=8'b1001_0100, out_ready low for 3 cycles on the first beat.
//     -> out_valid=1, out_pos=2, out_cnt=0 held stable for 3 cycles; sequence then resumes 4,7.
//  4. MSB_FIRST=1, in_data=8'b1001_0100. -> out_pos 7,4,2; out_last on pos 2.
//  5. Back-to-back: 8'h01 (tag 1) then 8'h80 (tag 2), in_valid continuous, out_ready=1.
//     -> pos 0/tag 1/last, then pos 7/tag 2/last on the next cycle; no idle cycle.
//  6. in_data=8'hFF, rst_n low after 2 beats.
//     -> next cycle out_valid=0, busy=0, in_ready=1; then 8'h10 -> single beat, pos 4, cnt 0.

Source files
------------

// File: rtl/lnzd_scanner_pkg.sv
// Shared types and helpers for the LNZD scanner.
// State encoding and width helper.
package lnzd_scanner_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lnzd_scanner_lnzd.sv
// Leading-nonzero detector: lowest set bit index.
// vld doubles as "input is nonzero".
module lnzd_scanner_lnzd
  import lnzd_scanner_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0]        d,
  output logic [clog2(BIT_WIDTH)-1:0] pos,
  output logic                        vld
);

  localparam int PW = clog2(BIT_WIDTH);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    pos = '0;
    vld = |d;
    for (int i = BIT_WIDTH - 1; i >= 0; i--) begin
      if (d[i]) pos = PW'(i);
    end
  end

endmodule

// File: rtl/lnzd_scanner.sv
// Streams the nonzero bit positions of a vector,
// one per beat, tagged with the vector's id.
module lnzd_scanner
  import lnzd_scanner_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [clog2(DATA_WIDTH)-1:0] out_pos,
  output logic [clog2(DATA_WIDTH):0]   out_cnt,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic                         out_last,
  output logic                         out_empty,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int PW = clog2(DATA_WIDTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_WIDTH-1:0] ONE =
    DATA_WIDTH'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] res;
  logic [TAG_WIDTH-1:0]  tag;
  logic [CW-1:0]         cnt;

  logic [DATA_WIDTH-1:0] rev;
  logic [DATA_WIDTH-1:0] det_in;
  logic [PW-1:0]         det_pos;
  logic                  det_vld;
  logic [DATA_WIDTH-1:0] onehot;
  logic                  xfer;
  logic                  accept;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_rev
    assign rev[g] = res[DATA_WIDTH-1-g];
  end

  assign det_in = (MSB_FIRST != 0) ? rev : res;

  lnzd_scanner_lnzd #(
    .BIT_WIDTH(DATA_WIDTH)
  ) u_lnzd (
    .d  (det_in),
    .pos(det_pos),
    .vld(det_vld)
  );

  // Zero residual reports position 0, in either order.
  always_comb begin
    out_pos = '0;
    if (det_vld) begin
      if (MSB_FIRST != 0)
        out_pos = PW'(DATA_WIDTH - 1) - det_pos;
      else
        out_pos = det_pos;
    end
  end

  assign onehot    = ONE << out_pos;
  assign out_valid = (state == SCAN);
  assign busy      = (state == SCAN);
  assign out_cnt   = cnt;
  assign out_tag   = tag;
  assign out_empty = (state == SCAN) & ~det_vld;
  assign out_last  = (state == SCAN) &
                     ((res & (res - ONE)) == '0);
  assign xfer      = out_valid & out_ready;
  assign in_ready  = (state == IDLE) |
                     (xfer & out_last);
  assign accept    = in_valid & in_ready;

  // Load on accept, else retire one bit per beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      res   <= '0;
      tag   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SCAN;
      res   <= in_data;
      tag   <= in_tag;
      cnt   <= '0;
    end else if (xfer) begin
      res <= res & ~onehot;
      cnt <= cnt + CW'(1);
      if (out_last) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_lnzd_scanner.sv
// Self-checking bench for lnzd_scanner (8-bit),
// LSB-first and MSB-first instances in lockstep.
module tb_lnzd_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [7:0] in_tag;
  logic       in_valid;
  logic       out_ready;

  logic       a_in_ready, a_last, a_empty;
  logic       a_valid, a_busy;
  logic [2:0] a_pos;
  logic [3:0] a_cnt;
  logic [7:0] a_tag;

  logic       b_in_ready, b_last, b_empty;
  logic       b_valid, b_busy;
  logic [2:0] b_pos;
  logic [3:0] b_cnt;
  logic [7:0] b_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lnzd_scanner #(
    .DATA_WIDTH(8), .TAG_WIDTH(8), .MSB_FIRST(0)
  ) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .out_pos(a_pos), .out_cnt(a_cnt),
    .out_tag(a_tag), .out_last(a_last),
    .out_empty(a_empty), .out_valid(a_valid),
    .out_ready(out_ready), .busy(a_busy)
  );

  lnzd_scanner #(
    .DATA_WIDTH(8), .TAG_WIDTH(8), .MSB_FIRST(1)
  ) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .out_pos(b_pos), .out_cnt(b_cnt),
    .out_tag(b_tag), .out_last(b_last),
    .out_empty(b_empty), .out_valid(b_valid),
    .out_ready(out_ready), .busy(b_busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm,
                          input int lp, input int mp,
                          input int cnt,
                          input logic [7:0] tag,
                          input bit last,
                          input bit empty);
    chk({nm, ".valid"}, 32'(a_valid), 1);
    chk({nm, ".busy"}, 32'(a_busy), 1);
    chk({nm, ".lpos"}, 32'(a_pos), lp);
    chk({nm, ".mpos"}, 32'(b_pos), mp);
    chk({nm, ".cnt"}, 32'(a_cnt), cnt);
    chk({nm, ".mcnt"}, 32'(b_cnt), cnt);
    chk({nm, ".tag"}, 32'(a_tag), 32'(tag));
    chk({nm, ".mtag"}, 32'(b_tag), 32'(tag));
    chk({nm, ".last"}, 32'(a_last), 32'(last));
    chk({nm, ".mlast"}, 32'(b_last), 32'(last));
    chk({nm, ".empty"}, 32'(a_empty), 32'(empty));
    chk({nm, ".mempty"}, 32'(b_empty), 32'(empty));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".valid"}, 32'(a_valid), 0);
    chk({nm, ".mvalid"}, 32'(b_valid), 0);
    chk({nm, ".busy"}, 32'(a_busy), 0);
    chk({nm, ".rdy"}, 32'(a_in_ready), 1);
    chk({nm, ".mrdy"}, 32'(b_in_ready), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] tag;
    int         n;
    bit         empty;
    int         pos[8];
  } vec_t;

  typedef struct {
    int         lp;
    int         mp;
    int         cnt;
    logic [7:0] tag;
    bit         last;
    bit         empty;
  } beat_t;

  vec_t  tbl[6];
  beat_t q[$];

  task automatic push_vec(input logic [7:0] d,
                          input logic [7:0] t);
    int    lst[$];
    beat_t b;
    for (int i = 0; i < 8; i++)
      if (d[i]) lst.push_back(i);
    if (lst.size() == 0) begin
      b = '{0, 0, 0, t, 1'b1, 1'b1};
      q.push_back(b);
    end else begin
      for (int k = 0; k < lst.size(); k++) begin
        b.lp    = lst[k];
        b.mp    = lst[lst.size() - 1 - k];
        b.cnt   = k;
        b.tag   = t;
        b.last  = (k == lst.size() - 1);
        b.empty = 1'b0;
        q.push_back(b);
      end
    end
  endtask

  initial begin
    bit   exp_rdy;
    int   r;

    tbl[0].data = 8'b1001_0100; tbl[0].tag = 8'd5;
    tbl[0].n = 3; tbl[0].empty = 0;
    tbl[0].pos = '{2, 4, 7, 0, 0, 0, 0, 0};
    tbl[1].data = 8'h00; tbl[1].tag = 8'd9;
    tbl[1].n = 1; tbl[1].empty = 1;
    tbl[1].pos = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].data = 8'hFF; tbl[2].tag = 8'd3;
    tbl[2].n = 8; tbl[2].empty = 0;
    tbl[2].pos = '{0, 1, 2, 3, 4, 5, 6, 7};
    tbl[3].data = 8'h01; tbl[3].tag = 8'd1;
    tbl[3].n = 1; tbl[3].empty = 0;
    tbl[3].pos = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4].data = 8'h80; tbl[4].tag = 8'd2;
    tbl[4].n = 1; tbl[4].empty = 0;
    tbl[4].pos = '{7, 0, 0, 0, 0, 0, 0, 0};
    tbl[5].data = 8'b0110_0000; tbl[5].tag = 8'hAA;
    tbl[5].n = 2; tbl[5].empty = 0;
    tbl[5].pos = '{5, 6, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0; in_data = '0; in_tag = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("reset");
    chk("reset.pos", 32'(a_pos), 0);
    chk("reset.mpos", 32'(b_pos), 0);
    chk("reset.cnt", 32'(a_cnt), 0);
    chk("reset.tag", 32'(a_tag), 0);
    chk("reset.last", 32'(a_last), 0);
    chk("reset.empty", 32'(a_empty), 0);

    // Table-driven vectors, out_ready held high.
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = tbl[e].data;
      in_tag   = tbl[e].tag;
      #1;
      chk($sformatf("tbl%0d.rdy", e),
          32'(a_in_ready), 1);
      for (int k = 0; k < tbl[e].n; k++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk_beat($sformatf("tbl%0d.b%0d", e, k),
                 tbl[e].pos[k],
                 tbl[e].pos[tbl[e].n - 1 - k],
                 k, tbl[e].tag,
                 k == tbl[e].n - 1, tbl[e].empty);
        if (k == tbl[e].n - 1)
          chk($sformatf("tbl%0d.lastrdy", e),
              32'(a_in_ready), 1);
      end
      @(negedge clk);
      #1;
      chk_idle($sformatf("tbl%0d.end", e));
    end

    // Stall on the first beat.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'b1001_0100;
    in_tag = 8'd7; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk_beat($sformatf("stall.c%0d", i),
               2, 7, 0, 8'd7, 0, 0);
      chk("stall.rdy", 32'(a_in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk_beat("stall.b1", 4, 4, 1, 8'd7, 0, 0);
    @(negedge clk); #1;
    chk_beat("stall.b2", 7, 2, 2, 8'd7, 1, 0);
    @(negedge clk); #1;
    chk_idle("stall.end");

    // Back-to-back with no bubble.
    in_valid = 1'b1; in_data = 8'h01; in_tag = 8'd1;
    @(negedge clk); #1;
    chk_beat("b2b.0", 0, 0, 0, 8'd1, 1, 0);
    chk("b2b.rdy", 32'(a_in_ready), 1);
    in_data = 8'h80; in_tag = 8'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_beat("b2b.1", 7, 7, 0, 8'd2, 1, 0);
    @(negedge clk); #1;
    chk_idle("b2b.end");

    // Reset mid-scan discards the vector.
    in_valid = 1'b1; in_data = 8'hFF; in_tag = 8'd4;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_beat("rst.b0", 0, 7, 0, 8'd4, 0, 0);
    @(negedge clk); #1;
    chk_beat("rst.b1", 1, 6, 1, 8'd4, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("rst.after");
    chk("rst.cnt", 32'(a_cnt), 0);
    chk("rst.tag", 32'(a_tag), 0);
    chk("rst.pos", 32'(a_pos), 0);
    in_valid = 1'b1; in_data = 8'h10; in_tag = 8'd6;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_beat("rst.new", 4, 4, 0, 8'd6, 1, 0);
    @(negedge clk); #1;
    chk_idle("rst.end");

    // Randomized traffic against the queue model.
    q.delete();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      chk("rnd.valid", 32'(a_valid),
          32'(q.size() != 0));
      chk("rnd.mvalid", 32'(b_valid),
          32'(q.size() != 0));
      if (q.size() != 0)
        chk_beat("rnd", q[0].lp, q[0].mp, q[0].cnt,
                 q[0].tag, q[0].last, q[0].empty);
      in_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 5);
      if (r == 0)      in_data = 8'h00;
      else if (r == 1) in_data = 8'hFF;
      else             in_data = 8'($urandom);
      in_tag    = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (q.size() == 0) ||
                (out_ready && q[0].last);
      chk("rnd.rdy", 32'(a_in_ready), 32'(exp_rdy));
      chk("rnd.mrdy", 32'(b_in_ready), 32'(exp_rdy));
      if (q.size() != 0 && out_ready)
        void'(q.pop_front());
      if (in_valid && exp_rdy)
        push_vec(in_data, in_tag);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
